// File: rtl/seven_segment_pkg.sv
// Shared types, segment pattern constants and the pattern-to-nibble decoder
// for the seven-segment bus reader.
package seven_segment_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;     // {A,B,C,D,E,F,G}, A = bit 6
  typedef logic [3:0] nibble_t;

  typedef struct packed {
    logic    ok;
    nibble_t nib;
  } decode_t;

  localparam seg_t SEG_0 = 7'b1111110;
  localparam seg_t SEG_1 = 7'b0110000;
  localparam seg_t SEG_2 = 7'b1101101;
  localparam seg_t SEG_3 = 7'b1111001;
  localparam seg_t SEG_4 = 7'b0110011;
  localparam seg_t SEG_5 = 7'b1011011;
  localparam seg_t SEG_6 = 7'b1011111;
  localparam seg_t SEG_7 = 7'b1110000;
  localparam seg_t SEG_8 = 7'b1111111;
  localparam seg_t SEG_9 = 7'b1111011;
  localparam seg_t SEG_A = 7'b1110111;
  localparam seg_t SEG_B = 7'b0011111;
  localparam seg_t SEG_C = 7'b1001110;
  localparam seg_t SEG_D = 7'b0111101;
  localparam seg_t SEG_E = 7'b1001111;
  localparam seg_t SEG_F = 7'b1000111;

  // Exact match only; blank and any partial pattern report ok = 0.
  function automatic decode_t seg_decode(input seg_t seg);
    decode_t r;
    r.ok  = 1'b1;
    r.nib = 4'h0;
    case (seg)
      SEG_0:   r.nib = 4'h0;
      SEG_1:   r.nib = 4'h1;
      SEG_2:   r.nib = 4'h2;
      SEG_3:   r.nib = 4'h3;
      SEG_4:   r.nib = 4'h4;
      SEG_5:   r.nib = 4'h5;
      SEG_6:   r.nib = 4'h6;
      SEG_7:   r.nib = 4'h7;
      SEG_8:   r.nib = 4'h8;
      SEG_9:   r.nib = 4'h9;
      SEG_A:   r.nib = 4'hA;
      SEG_B:   r.nib = 4'hB;
      SEG_C:   r.nib = 4'hC;
      SEG_D:   r.nib = 4'hD;
      SEG_E:   r.nib = 4'hE;
      SEG_F:   r.nib = 4'hF;
      default: r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_input_filter.sv
// Two-flop synchronizer for the raw {seg,dsen} pins followed by a saturating
// stability counter on the synchronized value.
module seg_input_filter #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] din,
  output logic [10:0] s,
  output logic        stable,
  output logic        changed
);

  localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [10:0]   sync1_q;
  logic [10:0]   s_q;
  logic [10:0]   s_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count restarts in the same cycle the synchronized value moves, so cnt is
  // already 0 in the first cycle s differs from its previous value.
  always_comb begin
    cnt_d = cnt_q;
    if (sync1_q != s_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      s_q      <= '0;
      s_prev_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      s_q      <= sync1_q;
      s_prev_q <= s_q;
      cnt_q    <= cnt_d;
    end
  end

  assign s       = s_q;
  assign stable  = (cnt_q == CNT_MAX);
  assign changed = (s_q != s_prev_q);

endmodule

// File: rtl/seven_segment_capture.sv
// Multiplexed 4-digit seven-segment bus reader: accepts one strobe per stable
// window, decodes it per digit, and flags frames, bad patterns and a dead bus.
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      seg_in,
  input  logic [3:0]      dsen_in,
  output logic [3:0][3:0] digit_out,
  output logic [3:0]      digit_valid,
  output logic            frame_done,
  output logic            decode_err,
  output logic            stale
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic {StSettle, StHeld} state_t;

  logic [10:0] s;
  logic        stable;
  logic        changed;

  seg_input_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .din    ({seg_in, dsen_in}),
    .s      (s),
    .stable (stable),
    .changed(changed)
  );

  seg_t    s_seg;
  logic [3:0] s_dsen;
  decode_t dec;
  logic    dsen_onehot;

  assign s_seg       = s[10:4];
  assign s_dsen      = s[3:0];
  assign dec         = seg_decode(s_seg);
  assign dsen_onehot = (s_dsen != 4'b0000) && ((s_dsen & (s_dsen - 4'd1)) == 4'b0000);

  state_t state_q, state_d;
  logic   accept;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StSettle: begin
        if (stable) begin
          accept  = dsen_onehot;
          state_d = StHeld;
        end
      end
      StHeld: begin
        if (changed) begin
          state_d = StSettle;
        end
      end
      default: state_d = StSettle;
    endcase
  end

  logic [3:0][3:0] digit_q, digit_d;
  logic [3:0]      valid_q, valid_d;
  logic [3:0]      seen_q, seen_d;
  logic            frame_q, frame_d;
  logic            err_q, err_d;
  logic            stale_q, stale_d;
  logic [TW-1:0]   to_q, to_d;
  logic            acc_ok;

  assign acc_ok = accept & dec.ok;

  always_comb begin
    digit_d = digit_q;
    valid_d = valid_q;
    seen_d  = seen_q;
    frame_d = 1'b0;
    err_d   = accept & ~dec.ok;
    stale_d = stale_q;
    to_d    = to_q;

    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (accept && s_dsen[n]) begin
        if (dec.ok) begin
          digit_d[n] = dec.nib;
          valid_d[n] = 1'b1;
          seen_d[n]  = 1'b1;
        end else begin
          valid_d[n] = 1'b0;
        end
      end
    end

    if (seen_d == 4'b1111) begin
      frame_d = 1'b1;
      seen_d  = 4'b0000;
    end

    // A good accept always wins over the timeout firing in the same cycle.
    if (acc_ok) begin
      to_d    = '0;
      stale_d = 1'b0;
    end else begin
      if (to_q != TO_MAX) begin
        to_d = to_q + TW'(1);
      end
      if (to_d == TO_MAX) begin
        stale_d = 1'b1;
        valid_d = 4'b0000;
        seen_d  = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StSettle;
      digit_q <= '0;
      valid_q <= '0;
      seen_q  <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      stale_q <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      seen_q  <= seen_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      stale_q <= stale_d;
      to_q    <= to_d;
    end
  end

  assign digit_out   = digit_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign decode_err  = err_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with STABLE_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_seven_segment_capture;

  localparam logic [6:0] P_BLANK = 7'b0000000;
  localparam logic [6:0] P_0 = 7'b1111110;
  localparam logic [6:0] P_1 = 7'b0110000;
  localparam logic [6:0] P_2 = 7'b1101101;
  localparam logic [6:0] P_3 = 7'b1111001;
  localparam logic [6:0] P_4 = 7'b0110011;
  localparam logic [6:0] P_5 = 7'b1011011;
  localparam logic [6:0] P_6 = 7'b1011111;
  localparam logic [6:0] P_7 = 7'b1110000;
  localparam logic [6:0] P_8 = 7'b1111111;
  localparam logic [6:0] P_9 = 7'b1111011;
  localparam logic [6:0] P_A = 7'b1110111;
  localparam logic [6:0] P_C = 7'b1001110;
  localparam logic [6:0] P_D = 7'b0111101;
  localparam logic [6:0] P_E = 7'b1001111;
  localparam logic [6:0] P_F = 7'b1000111;

  logic            clk = 1'b0;
  logic            rst;
  logic [6:0]      seg_in;
  logic [3:0]      dsen_in;
  logic [3:0][3:0] digit_out;
  logic [3:0]      digit_valid;
  logic            frame_done;
  logic            decode_err;
  logic            stale;

  int n_checks = 0;
  int n_errors = 0;
  int fd_total = 0;
  int de_total = 0;
  int fd0, de0;

  seven_segment_capture #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .dsen_in    (dsen_in),
    .digit_out  (digit_out),
    .digit_valid(digit_valid),
    .frame_done (frame_done),
    .decode_err (decode_err),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      fd_total += int'(frame_done);
      de_total += int'(decode_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic [6:0] seg);
    seg_in  = seg;
    dsen_in = 4'b0001 << d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    seg_in  = '0;
    dsen_in = '0;
    do_reset();
    check("reset_digits", 32'(digit_out), 32'h0);
    check("reset_valid", 32'(digit_valid), 32'h0);
    check("reset_frame", 32'(frame_done), 32'h0);
    check("reset_err", 32'(decode_err), 32'h0);
    check("reset_stale", 32'(stale), 32'h0);

    // Basic scan 1,2,3,4 with latency check on digit 3.
    fd0 = fd_total;
    drive(0, P_1); tick(8);
    drive(1, P_2); tick(8);
    drive(2, P_3); tick(8);
    drive(3, P_4); tick(5);
    check("lat_before", 32'(digit_out[3]), 32'h0);
    tick(1);
    check("lat_at", 32'(digit_out[3]), 32'h4);
    check("lat_frame", 32'(frame_done), 32'h1);
    tick(2);
    check("scan_digits", 32'(digit_out), 32'h4321);
    check("scan_valid", 32'(digit_valid), 32'hF);
    check("scan_frames", 32'(fd_total - fd0), 32'd1);

    // Blank pattern on digit 2 mid-scan.
    fd0 = fd_total; de0 = de_total;
    drive(0, P_5); tick(8);
    drive(1, P_6); tick(8);
    drive(2, P_BLANK); tick(8);
    drive(3, P_7); tick(8);
    check("blank_digits", 32'(digit_out), 32'h7365);
    check("blank_valid", 32'(digit_valid), 32'hB);
    check("blank_errs", 32'(de_total - de0), 32'd1);
    check("blank_frames", 32'(fd_total - fd0), 32'd0);
    drive(2, P_8); tick(8);
    check("fill_digits", 32'(digit_out), 32'h7865);
    check("fill_valid", 32'(digit_valid), 32'hF);
    check("fill_frames", 32'(fd_total - fd0), 32'd1);

    // Two-cycle glitch inside the window.
    de0 = de_total;
    drive(0, P_9); tick(3);
    seg_in = P_BLANK; tick(2);
    seg_in = P_9; tick(10);
    check("glitch_digits", 32'(digit_out), 32'h7869);
    check("glitch_errs", 32'(de_total - de0), 32'd0);

    // Multi-hot enables are ignored; single enable accepted.
    de0 = de_total;
    seg_in = P_0; dsen_in = 4'b0110; tick(8);
    check("multihot_digits", 32'(digit_out), 32'h7869);
    check("multihot_errs", 32'(de_total - de0), 32'd0);
    dsen_in = 4'b0100; tick(8);
    check("onehot_digits", 32'(digit_out), 32'h7069);
    check("onehot_valid", 32'(digit_valid), 32'hF);

    // Timeout after a frozen bus, then recovery.
    do_reset();
    fd0 = fd_total;
    drive(0, P_C); tick(8);
    drive(1, P_D); tick(8);
    drive(2, P_E); tick(8);
    drive(3, P_F); tick(6);
    check("to_frame", 32'(frame_done), 32'h1);
    tick(19);
    check("to_not_yet", 32'(stale), 32'h0);
    check("to_valid_pre", 32'(digit_valid), 32'hF);
    tick(1);
    check("to_stale", 32'(stale), 32'h1);
    check("to_valid", 32'(digit_valid), 32'h0);
    check("to_digits", 32'(digit_out), 32'hFEDC);
    drive(0, P_A); tick(6);
    check("rec_stale", 32'(stale), 32'h0);
    check("rec_digits", 32'(digit_out), 32'hFEDA);
    check("rec_valid", 32'(digit_valid), 32'h1);
    check("to_frames", 32'(fd_total - fd0), 32'd1);

    // Reset two cycles into a stable window.
    drive(1, P_2); tick(2);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    check("mrst_digits", 32'(digit_out), 32'h0);
    check("mrst_valid", 32'(digit_valid), 32'h0);
    check("mrst_stale", 32'(stale), 32'h0);
    tick(5);
    check("mrst_wait", 32'(digit_out), 32'h0);
    tick(1);
    check("mrst_digits2", 32'(digit_out), 32'h0020);
    check("mrst_valid2", 32'(digit_valid), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Reader for a multiplexed 4-digit seven-segment bus: the other end of the digit-scan interface the display driver produces.
- Samples the segment lines and digit enables and decodes each segment pattern back to a hex nibble.
- Holds the last good value per digit and flags frame completion, illegal patterns and a dead bus.
- Sits at the FPGA pins for bus sniffing and self-test loopback of the display path.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a digit is accepted (min 1).
- TIMEOUT_CYCLES, 65535: cycles without any accepted digit before the bus is declared stale (min 1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- seg_in  input  7  segments {A,B,C,D,E,F,G}, A = bit 6, active-high, asynchronous to clk
- dsen_in  input  4  digit enables, bit n = digit n, active-high, asynchronous
- digit_out  output  4x4  last accepted nibble per digit, digit_out[n]
- digit_valid  output  4  bit n set while digit_out[n] holds a good decode
- frame_done  output  1  one-cycle pulse when all four digits are accepted since the last pulse
- decode_err  output  1  one-cycle pulse on an accepted strobe with an unknown pattern
- stale  output  1  level; bus silent for TIMEOUT_CYCLES

Behaviour:
- Reset (rst=1 at a clk edge): digit_out=0, digit_valid=0, frame_done=0, decode_err=0, stale=0, sync flops=0, filter counter=0, seen mask=0, timeout counter=0, FSM=SETTLE.
- Input path: 11-bit {seg_in,dsen_in} passes through a two-flop synchronizer; all logic below uses the synchronized value s.
- Stability filter: cnt clears to 0 whenever s differs from its previous-cycle value, otherwise saturates at STABLE_CYCLES-1.
- FSM states:
  - SETTLE: wait for cnt==STABLE_CYCLES-1. If dsen part of s is one-hot, perform the accept and go to HELD. If it is not one-hot (0000 or multiple bits), no accept and go to HELD.
  - HELD: stay until s changes, then go to SETTLE. Guarantees one accept per strobe window.
- Accept for digit n, with outputs registered on the accept edge:
  - Known pattern: digit_out[n] gets the nibble, digit_valid[n]=1, seen[n]=1.
  - Unknown pattern: digit_out[n] unchanged, digit_valid[n]=0, decode_err=1 for one cycle, seen[n] unchanged.
- Decode table (ABCDEFG to nibble), exact match only:
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3
  - 0110011=4, 1011011=5, 1011111=6, 1110000=7
  - 1111111=8, 1111011=9, 1110111=A, 0011111=b
  - 1001110=C, 0111101=d, 1001111=E, 1000111=F
  - Anything else is unknown, including 0000000 (blank).
- Latency: a change on the pins that is held steady is reflected on digit_out exactly STABLE_CYCLES+2 edges after the first edge sampling it (2 sync + STABLE_CYCLES filter, accept registered).
- Frame: when the next value of seen equals 1111, frame_done pulses that same cycle and seen clears to 0000. The current accept's bit counts toward this frame.
- Timeout:
  - Counter clears on every successful accept, otherwise increments.
  - On reaching TIMEOUT_CYCLES: stale=1, digit_valid=0000, seen=0000, counter holds.
  - stale clears on the next successful accept; that accept's digit_valid bit sets in the same cycle.
- Simultaneous events: a successful accept in the cycle the counter would hit TIMEOUT_CYCLES wins (no stale). frame_done and decode_err cannot coincide.
- Repeated strobe of the same digit within a frame updates digit_out[n]; seen is unaffected beyond already being set.
- Glitch shorter than STABLE_CYCLES: filter restarts, no accept, no error.
- Reset mid-window: all state cleared, and the next accept requires a fresh STABLE_CYCLES of stable samples.

Decomposition:
- Package seven_segment_pkg:
  - NUM_DIGITS=4
  - seg_t (7-bit) and nibble_t (4-bit) typedefs
  - The 16 SEG_x pattern constants
  - A pure function seg_decode(seg_t) returning {ok, nibble_t}
- Sub-module seg_input_filter: two-flop synchronizer plus stability counter. Outputs s and stable (cnt==STABLE_CYCLES-1). Parameter STABLE_CYCLES.
- The top-level holds the FSM, per-digit registers, seen mask and timeout.

Test Plan:
- Reset then scan digits 0..3 with 1,2,3,4 patterns, each held 8 cycles, STABLE_CYCLES=4 -> digit_out={4,3,2,1} (digit 3..0), digit_valid=1111, one frame_done pulse on the digit-3 accept, which occurs 6 edges after digit-3 is applied.
- Digit 2 driven 0000000 during a valid scan -> decode_err pulses once, digit_valid=1011, digit_out[2] keeps its old value, no frame_done that frame.
- 2-cycle glitch on seg_in mid-window with STABLE_CYCLES=4 -> no extra accept, no decode_err; steady value accepted once after the glitch.
- dsen_in=0110 held steady with a valid pattern -> no accept, no output change; then dsen_in=0100 -> digit 2 accepted.
- TIMEOUT_CYCLES=20, bus frozen after a good frame -> stale=1 and digit_valid=0000 at edge 20 after the last accept. A following digit-0 "A" (1110111) -> stale=0, digit_out[0]=A, digit_valid=0001.
- rst asserted 2 cycles into a stable window -> all outputs 0 next edge; same input must wait STABLE_CYCLES+2 more edges before accept.
